bioee_vector_capture: RTL

- Return path for the vector interface: samples the chip's 16-bit vector response bus on vectorclk and buffers the captured words for readback to the PC.
- Capture is armed by the host and starts on a masked pattern trigger. It runs for a programmed number of samples, with optional decimation.
- Captured words are held in an internal single-clock FIFO and presented on a valid/ready stream. That stream feeds the existing pipe-out clock-crossing FIFO, which sits outside this block.

---
 rtl/bioee_vector_capture.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/bioee_vector_capture.sv
// Purpose  : triggered capture of the 16-bit vector response bus into a FWFT buffer.
// Latency  : bus -> vin_q 1 cycle; a stored word is visible on out_data 1 cycle after its store edge.
// Backpress: out_ready low holds the head word. When the buffer is full a store is dropped and sets overflow.
//
// Ports (bioee_vector_capture):
//   vectorclk, vectorreset        capture clock and async active-high reset
//   vectorinput                   chip response bus, registered into vin_q every edge
//   arm, abort                    host control pulses (abort has priority)
//   trig_mask, trig_pattern       masked compare applied to vin_q
//   sample_count, decim           capture length and keep-1-in-(decim+1), latched on arm
//   out_data/out_valid/out_ready  first-word-fall-through read stream
//   busy, done, overflow          status; overflow is sticky until the next arm
//   fill_level                    buffer occupancy, 0 .. 2^ADDR_W

// Purpose  : single-clock FWFT FIFO, 2^AW words, with a count of occupancy.
// Latency  : a write is readable on rd_data_o the cycle after the write edge.
// Backpress: a write while full is refused unless a read happens in the same cycle.
//
// Ports (bioee_sync_fifo):
//   wr_en_i/wr_data_i   write request and data; wr_acc_o reports that the word was taken
//   rd_en_i             pop the head word (ignored when empty)
//   rd_data_o           head word, 0 when empty
//   count_o             number of stored words
module bioee_sync_fifo #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_acc_o,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic [AW:0]   count_o
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          empty;
    logic          rd_acc;
    logic          wr_acc;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign rd_acc = rd_en_i && !empty;
    // When full, the slot being written is the one being read out this cycle,
    // so a simultaneous pop makes room for the incoming word.
    assign wr_acc = wr_en_i && (!full || rd_acc);

    assign wr_acc_o  = wr_acc;
    assign rd_data_o = empty ? '0 : mem_q[rptr_q];
    assign count_o   = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array is not reset; occupancy tracking alone defines valid contents.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end
endmodule

module bioee_vector_capture #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              vectorclk,
    input  logic              vectorreset,
    input  logic [DATA_W-1:0] vectorinput,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_pattern,
    input  logic [15:0]       sample_count,
    input  logic [7:0]        decim,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   fill_level
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] vin_q;
    logic [15:0]       cnt_q, cnt_d;      // store attempts still to make
    logic [7:0]        decim_q, decim_d;
    logic [7:0]        phase_q, phase_d;  // cycles until the next kept sample
    logic              overflow_q, overflow_d;

    logic              trig_hit;
    logic              last_attempt;
    logic              arm_go;
    logic              store_attempt;
    logic              wr_acc;
    logic              pop;
    logic [ADDR_W:0]   fifo_count;

    assign trig_hit     = (((vin_q ^ trig_pattern) & trig_mask) == '0);
    assign last_attempt = (cnt_q == 16'd1);

    // ---------------- state register ----------------
    always_ff @(posedge vectorclk or posedge vectorreset) begin
        if (vectorreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm && !abort) begin
                    state_d = (sample_count != 16'd0) ? S_ARMED : S_DONE;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (trig_hit) begin
                    // A one-sample capture completes on the trigger edge itself.
                    state_d = last_attempt ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (phase_q == 8'd0 && last_attempt) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        arm_go        = 1'b0;
        store_attempt = 1'b0;
        case (state_q)
            S_IDLE: begin
                arm_go = arm && !abort;
            end
            S_ARMED: begin
                busy          = 1'b1;
                store_attempt = trig_hit && !abort;
            end
            S_CAPTURE: begin
                busy          = 1'b1;
                store_attempt = (phase_q == 8'd0) && !abort;
            end
            S_DONE: begin
                done   = 1'b1;
                arm_go = arm && !abort;
            end
            default: ;
        endcase
    end

    // ---------------- capture datapath ----------------
    always_comb begin
        cnt_d      = cnt_q;
        decim_d    = decim_q;
        phase_d    = phase_q;
        overflow_d = overflow_q;
        if (arm_go) begin
            cnt_d      = sample_count;
            decim_d    = decim;
            overflow_d = 1'b0;
        end
        if (store_attempt) begin
            // Dropped words still consume one of the programmed samples.
            cnt_d   = cnt_q - 16'd1;
            phase_d = decim_q;
            if (!wr_acc) begin
                overflow_d = 1'b1;
            end
        end else if (state_q == S_CAPTURE && !abort) begin
            phase_d = phase_q - 8'd1;
        end
    end

    always_ff @(posedge vectorclk or posedge vectorreset) begin
        if (vectorreset) begin
            vin_q      <= '0;
            cnt_q      <= '0;
            decim_q    <= '0;
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            vin_q      <= vectorinput;
            cnt_q      <= cnt_d;
            decim_q    <= decim_d;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- buffer ----------------
    assign pop = out_valid && out_ready;

    bioee_sync_fifo #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_buf (
        .clk       (vectorclk),
        .rst       (vectorreset),
        .wr_en_i   (store_attempt),
        .wr_data_i (vin_q),
        .wr_acc_o  (wr_acc),
        .rd_en_i   (pop),
        .rd_data_o (out_data),
        .count_o   (fifo_count)
    );

    assign out_valid  = (fifo_count != '0);
    assign fill_level = fifo_count;
    assign overflow   = overflow_q;
endmodule
